bus_invert_rx: RTL and testbench

Receive-side endpoint for the bus-invert coded link.
- Accepts raw bus words plus the invert line under a valid/ready handshake.
- Restores the original data and buffers it in a small first-word-fall-through FIFO for the downstream consumer.
- Checks every accepted word against the encoder's invert rule and flags violations.
- Counts physical line toggles, including the invert line, so the switched-activity saving can be measured on silicon and in simulation.

---
 rtl/bus_invert_rx_if.sv | 22 ++
 rtl/bus_invert_rx.sv | 106 ++++++++++
 tb/tb_bus_invert_rx.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_invert_rx_if.sv
// rtl/bus_invert_rx_if.sv - coded-bus input and decoded-word output handshakes
interface bus_invert_rx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] bus_data;
    logic              bus_inv;
    logic              bus_valid;
    logic              bus_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  bus_data, bus_inv, bus_valid, out_ready,
        output bus_ready, out_data, out_valid
    );

    modport master (
        output bus_data, bus_inv, bus_valid, out_ready,
        input  bus_ready, out_data, out_valid
    );
endinterface

// File: rtl/bus_invert_rx.sv
// rtl/bus_invert_rx.sv - bus-invert decoder with FWFT buffer, rule checker and toggle counter
module bus_invert_rx #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_invert_rx_if.slave     bus,
    input  logic               clr_stats,
    output logic               proto_err,
    output logic [CNT_W-1:0]   toggle_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DATA_W + 2);
    localparam logic [CW-1:0] HALF = CW'(DATA_W / 2);

    typedef enum logic [1:0] {LVL_EMPTY, LVL_PARTIAL, LVL_FULL} level_e;

    function automatic logic [CW-1:0] popcnt(input logic [DATA_W-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    level_e            level;
    logic [AW:0]       count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] prev_bus_q;
    logic              prev_inv_q;
    logic              proto_err_q, proto_err_d;
    logic [CNT_W-1:0]  toggle_cnt_q, toggle_cnt_d;
    logic              accept, pop, legal;
    logic [DATA_W-1:0] decoded;
    logic [CW-1:0]     hamming, inc;
    logic [CNT_W:0]    sum;

    always_comb begin
        level = LVL_PARTIAL;
        if (count_q == '0)                  level = LVL_EMPTY;
        else if (count_q == (AW+1)'(DEPTH)) level = LVL_FULL;
    end

    // Ready depends only on the registered occupancy, never on out_ready.
    assign bus.bus_ready = (level != LVL_FULL);
    assign bus.out_valid = (level != LVL_EMPTY);
    assign bus.out_data  = (level != LVL_EMPTY) ? mem_q[rd_ptr_q] : hold_q;

    assign accept  = bus.bus_valid && bus.bus_ready;
    assign pop     = bus.out_valid && bus.out_ready;
    assign decoded = bus.bus_inv ? ~bus.bus_data : bus.bus_data;
    assign count_d = count_q + (AW+1)'(accept) - (AW+1)'(pop);

    always_comb begin
        hamming      = popcnt(decoded ^ prev_bus_q);
        inc          = popcnt(bus.bus_data ^ prev_bus_q) + CW'(bus.bus_inv ^ prev_inv_q);
        legal        = bus.bus_inv ? (hamming > HALF) : (hamming <= HALF);
        sum          = {1'b0, toggle_cnt_q} + (CNT_W+1)'(inc);
        proto_err_d  = proto_err_q;
        toggle_cnt_d = toggle_cnt_q;
        if (clr_stats) begin
            proto_err_d  = 1'b0;
            toggle_cnt_d = '0;
        end else if (accept) begin
            if (!legal) proto_err_d = 1'b1;
            toggle_cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            hold_q       <= '0;
            prev_bus_q   <= '0;
            prev_inv_q   <= 1'b0;
            proto_err_q  <= 1'b0;
            toggle_cnt_q <= '0;
        end else begin
            count_q      <= count_d;
            proto_err_q  <= proto_err_d;
            toggle_cnt_q <= toggle_cnt_d;
            if (accept) begin
                wr_ptr_q   <= wr_ptr_q + AW'(1);
                prev_bus_q <= bus.bus_data;
                prev_inv_q <= bus.bus_inv;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                hold_q   <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= decoded;
    end

    assign proto_err  = proto_err_q;
    assign toggle_cnt = toggle_cnt_q;
endmodule

// File: tb/tb_bus_invert_rx.sv
// tb/tb_bus_invert_rx.sv - randomized and directed bench for bus_invert_rx with a behavioural model
module tb_bus_invert_rx;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr_stats = 1'b0;
    logic             proto_err;
    logic [CNT_W-1:0] toggle_cnt;

    bus_invert_rx_if #(.DATA_W(DATA_W)) bif();

    bus_invert_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bif.slave),
        .clr_stats  (clr_stats),
        .proto_err  (proto_err),
        .toggle_cnt (toggle_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mq[$];
    logic [7:0] m_prev = 8'h00;
    logic       m_pinv = 1'b0;
    logic       m_err  = 1'b0;
    int         m_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of decoded words plus the statistics rules applied per accepted word.
    always @(posedge clk) begin
        logic       acc, pp, leg;
        logic [7:0] d;
        int         h, tog;
        if (!rst_n) begin
            mq.delete();
            m_prev = 8'h00; m_pinv = 1'b0; m_err = 1'b0; m_cnt = 0;
        end else begin
            acc = bif.bus_valid && (mq.size() < DEPTH);
            pp  = (mq.size() > 0) && bif.out_ready;
            if (pp) void'(mq.pop_front());
            if (acc) begin
                d   = bif.bus_inv ? ~bif.bus_data : bif.bus_data;
                h   = $countones(d ^ m_prev);
                leg = bif.bus_inv ? (h > DATA_W/2) : (h <= DATA_W/2);
                tog = $countones(bif.bus_data ^ m_prev) + ((bif.bus_inv != m_pinv) ? 1 : 0);
                if (clr_stats) begin
                    m_err = 1'b0; m_cnt = 0;
                end else begin
                    if (!leg) m_err = 1'b1;
                    m_cnt = (m_cnt + tog > CNT_MAX) ? CNT_MAX : m_cnt + tog;
                end
                m_prev = bif.bus_data;
                m_pinv = bif.bus_inv;
                mq.push_back(d);
            end else if (clr_stats) begin
                m_err = 1'b0; m_cnt = 0;
            end
        end
        #1;
        check("bus_ready", {31'b0, bif.bus_ready}, {31'b0, mq.size() < DEPTH});
        check("out_valid", {31'b0, bif.out_valid}, {31'b0, mq.size() > 0});
        if (mq.size() > 0) check("out_data", {24'b0, bif.out_data}, {24'b0, mq[0]});
        check("proto_err", {31'b0, proto_err}, {31'b0, m_err});
        check("toggle_cnt", {16'b0, toggle_cnt}, m_cnt);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bif.bus_valid = 1'b0;
        clr_stats = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic inv);
        bit done;
        done = 0;
        bif.bus_data  = d;
        bif.bus_inv   = inv;
        bif.bus_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            if (bif.bus_ready) done = 1;
            @(negedge clk);
        end
        bif.bus_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: got no bus_ready expected accept of %0h", d);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.bus_data = '0; bif.bus_inv = 1'b0; bif.bus_valid = 1'b0; bif.out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        check("reset_ready", {31'b0, bif.bus_ready}, 32'd1);
        check("reset_valid", {31'b0, bif.out_valid}, 32'd0);
        check("reset_cnt", {16'b0, toggle_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Inverted zero word, then a plain word toggling the invert line back.
        send(8'h00, 1'b1);
        check("t1_valid", {31'b0, bif.out_valid}, 32'd1);
        check("t1_data", {24'b0, bif.out_data}, 32'hFF);
        check("t1_err", {31'b0, proto_err}, 32'd0);
        check("t1_cnt", {16'b0, toggle_cnt}, 32'd1);
        send(8'h0F, 1'b0);
        check("t2_data", {24'b0, bif.out_data}, 32'h0F);
        check("t2_err", {31'b0, proto_err}, 32'd0);
        check("t2_cnt", {16'b0, toggle_cnt}, 32'd6);

        do_reset();
        send(8'hFF, 1'b0);
        check("t3_data", {24'b0, bif.out_data}, 32'hFF);
        check("t3_err", {31'b0, proto_err}, 32'd1);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        check("t3_clr_err", {31'b0, proto_err}, 32'd0);
        check("t3_clr_cnt", {16'b0, toggle_cnt}, 32'd0);

        do_reset();
        bif.out_ready = 1'b0;
        send(8'h00, 1'b1); send(8'h0F, 1'b0); send(8'h0E, 1'b0); send(8'h0C, 1'b0);
        check("t4_full", {31'b0, bif.bus_ready}, 32'd0);
        bif.out_ready = 1'b1;
        check("t4_pop0", {24'b0, bif.out_data}, 32'hFF);
        @(negedge clk);
        check("t4_ready", {31'b0, bif.bus_ready}, 32'd1);
        check("t4_pop1", {24'b0, bif.out_data}, 32'h0F);
        @(negedge clk);
        check("t4_pop2", {24'b0, bif.out_data}, 32'h0E);
        @(negedge clk);
        check("t4_pop3", {24'b0, bif.out_data}, 32'h0C);
        @(negedge clk);
        check("t4_empty", {31'b0, bif.out_valid}, 32'd0);

        do_reset();
        bif.out_ready = 1'b0;
        send(8'h01, 1'b0); send(8'h02, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bif.bus_data = 8'(8'h10 + i); bif.bus_inv = 1'b0; bif.bus_valid = 1'b1;
            bif.out_ready = 1'b1;
            @(negedge clk);
            check("t5_ready", {31'b0, bif.bus_ready}, 32'd1);
            check("t5_valid", {31'b0, bif.out_valid}, 32'd1);
            check("t5_head", {24'b0, bif.out_data}, (i == 0) ? 32'h02 : 32'(8'h10 + i - 1));
        end
        bif.bus_valid = 1'b0;
        check("t5_tail0", {24'b0, bif.out_data}, 32'h18);
        @(negedge clk);
        check("t5_tail1", {24'b0, bif.out_data}, 32'h19);
        @(negedge clk);

        for (int i = 0; i < 3000; i++) begin
            bif.bus_data  = 8'($urandom);
            bif.bus_inv   = 1'($urandom);
            bif.bus_valid = ($urandom_range(0, 3) != 0);
            bif.out_ready = (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr_stats     = ($urandom_range(0, 31) == 0);
            @(negedge clk);
        end
        clr_stats = 1'b0;

        do_reset();
        bif.out_ready = 1'b1;
        for (int i = 0; i < 8300; i++) begin
            bif.bus_data = (i % 2 == 0) ? 8'h00 : 8'hFF;
            bif.bus_inv = 1'b0; bif.bus_valid = 1'b1;
            @(negedge clk);
        end
        check("t6_sat", {16'b0, toggle_cnt}, 32'hFFFF);
        check("t6_err", {31'b0, proto_err}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'b0, bif.out_valid}, 32'd0);
        check("t6_rst_data", {24'b0, bif.out_data}, 32'd0);
        check("t6_rst_ready", {31'b0, bif.bus_ready}, 32'd1);
        check("t6_rst_err", {31'b0, proto_err}, 32'd0);
        check("t6_rst_cnt", {16'b0, toggle_cnt}, 32'd0);
        bif.bus_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
